// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and constants for the tc_timer countdown peripheral
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [31:0] TC_BASE_ADDR = 32'h0000_7F00;
  localparam logic [31:0] TC_SIZE      = 32'h0000_000C;

  // Bridge-side decode helper for a byte address.
  function automatic logic tc_addr_hit(input logic [31:0] byte_addr);
    return (byte_addr >= TC_BASE_ADDR) && (byte_addr < TC_BASE_ADDR + TC_SIZE);
  endfunction

endpackage

// File: rtl/tc_timer.sv
// rtl/tc_timer.sv - memory-mapped 32-bit countdown timer with one-shot/auto-reload irq
module tc_timer
  import tc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  state_t state, next_state;

  logic load_count, dec_count, set_flag, clr_flag, clr_en;

  logic [1:0] reg_sel;
  logic [1:0] mode;
  logic       wr_ctrl, wr_preset;
  logic       addr_unused;

  assign reg_sel     = addr[3:2];
  assign addr_unused = ^addr[31:4];
  assign mode        = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign wr_ctrl     = we && (reg_sel == REG_CTRL);
  assign wr_preset   = we && (reg_sel == REG_PRESET);

  assign irq = irq_flag & ctrl[CTRL_IM];

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata = {28'd0, ctrl};
      REG_PRESET: rdata = preset;
      REG_COUNT:  rdata = count;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_count = 1'b0;
    dec_count  = 1'b0;
    set_flag   = 1'b0;
    clr_flag   = 1'b0;
    clr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl[CTRL_EN]) next_state = LOAD;
      end
      LOAD: begin
        load_count = 1'b1;
        next_state = CNT;
      end
      CNT: begin
        if (!ctrl[CTRL_EN]) begin
          next_state = IDLE;
        end else if (count == '0) begin
          set_flag   = 1'b1;
          next_state = INT;
        end else begin
          dec_count = 1'b1;
        end
      end
      INT: begin
        // Codes 10/11 fall through to one-shot behaviour.
        if (mode == MODE_RELOAD) begin
          clr_flag   = 1'b1;
          next_state = LOAD;
        end else begin
          clr_en     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus writes are applied after FSM side effects so software always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (clr_en) ctrl[CTRL_EN] <= 1'b0;
      if (wr_ctrl) ctrl <= wdata[3:0];
      if (wr_preset) preset <= wdata;

      if (load_count) begin
        count <= preset;
      end else if (dec_count) begin
        count <= count - 32'd1;
      end

      if (wr_ctrl || wr_preset) begin
        irq_flag <= 1'b0;
      end else if (set_flag) begin
        irq_flag <= 1'b1;
      end else if (clr_flag) begin
        irq_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tc_timer.sv
// tb/tb_tc_timer.sv - scoreboard bench for tc_timer
module tb_tc_timer;
  import tc_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  tc_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       rise_q[$];
  int       cyc = 0;
  logic     irq_q = 1'b0;
  int       n_checks = 0;
  int       n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge index after which irq first reads high.
  always @(posedge clk) begin
    #3;
    if (irq && !irq_q) rise_q.push_back(cyc);
    irq_q = irq;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_compare(input logic [31:0] got);
    sb_item_t e;
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr  = {28'd0, a};
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
    addr = {28'd0, a};
    #1;
    sb_compare(rdata);
  endtask

  task automatic expect_rise(input string tag, input int exp_cyc, input int budget);
    int n;
    n = 0;
    sb_q.push_back('{tag, 32'(exp_cyc)});
    while (rise_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rise_q.size() == 0) sb_compare(32'hFFFF_FFFF);
    else sb_compare(32'(rise_q.pop_front()));
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 4; a++) read_expect(tag, 2'(a), 32'd0);
    check_eq({tag, "_irq"}, 32'(irq), 32'd0);
    check_eq({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  int wc;

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    step(2);
    check_all_zero("reset");
    reset = 1'b0;
    step(1);

    // One-shot, N=5: irq rises 8 edges after the CTRL write
    rise_q.delete();
    bus_write(REG_PRESET, 32'd5);
    bus_write(REG_CTRL, 32'h9);
    wc = cyc;
    read_expect("os_ctrl_running", REG_CTRL, 32'h9);
    expect_rise("os_rise", wc + 8, 20);
    step(1);
    read_expect("os_ctrl_after", REG_CTRL, 32'h8);
    check_eq("os_state_idle", 32'(dut.state), 32'(IDLE));
    step(3);
    check_eq("os_irq_hold", 32'(irq), 32'd1);
    bus_write(REG_CTRL, 32'h8);
    check_eq("os_irq_cleared", 32'(irq), 32'd0);

    // Auto-reload, N=3: period 6, one-cycle pulses
    rise_q.delete();
    bus_write(REG_PRESET, 32'd3);
    bus_write(REG_CTRL, 32'hB);
    wc = cyc;
    for (int p = 0; p < 4; p++) begin
      expect_rise($sformatf("ar_rise%0d", p), wc + 6 * (p + 1), 12);
      check_eq("ar_irq_high", 32'(irq), 32'd1);
      step(1);
      check_eq("ar_irq_pulse", 32'(irq), 32'd0);
      for (int k = 3; k >= 0; k--) begin
        step(1);
        read_expect("ar_count", REG_COUNT, 32'(k));
      end
    end
    // Write lands on the edge that would raise the flag: timeout is lost
    bus_write(REG_CTRL, 32'h0);
    check_eq("ar_lost_flag", 32'(dut.irq_flag), 32'd0);
    step(1);
    check_eq("ar_no_rise", 32'(rise_q.size()), 32'd0);
    check_eq("ar_state_idle", 32'(dut.state), 32'(IDLE));

    // Masked: flag sets but irq stays low
    rise_q.delete();
    bus_write(REG_PRESET, 32'd2);
    bus_write(REG_CTRL, 32'h1);
    step(7);
    check_eq("mask_irq", 32'(irq), 32'd0);
    check_eq("mask_flag_set", 32'(dut.irq_flag), 32'd1);
    check_eq("mask_no_rise", 32'(rise_q.size()), 32'd0);
    bus_write(REG_CTRL, 32'h8);
    check_eq("mask_flag_clr", 32'(dut.irq_flag), 32'd0);
    check_eq("mask_irq_after", 32'(irq), 32'd0);

    // Pause at COUNT=12, then re-enable reloads PRESET
    bus_write(REG_PRESET, 32'd20);
    bus_write(REG_CTRL, 32'h1);
    step(10);
    read_expect("pause_count12", REG_COUNT, 32'd12);
    bus_write(REG_CTRL, 32'h0);
    read_expect("pause_count_last", REG_COUNT, 32'd11);
    bus_write(REG_COUNT, 32'hDEAD_BEEF);
    step(9);
    read_expect("pause_count_held", REG_COUNT, 32'd11);
    check_eq("pause_state_idle", 32'(dut.state), 32'(IDLE));
    bus_write(2'd3, 32'h1234_5678);
    read_expect("reserved_reads0", 2'd3, 32'd0);
    read_expect("preset_intact", REG_PRESET, 32'd20);
    bus_write(REG_CTRL, 32'h1);
    step(2);
    read_expect("pause_reload", REG_COUNT, 32'd20);
    check_eq("pause_state_cnt", 32'(dut.state), 32'(CNT));
    bus_write(REG_CTRL, 32'h0);
    step(2);

    // PRESET=0: irq 3 edges after enabling
    rise_q.delete();
    bus_write(REG_PRESET, 32'd0);
    bus_write(REG_CTRL, 32'h9);
    wc = cyc;
    expect_rise("zero_rise", wc + 3, 10);
    bus_write(REG_CTRL, 32'h8);
    step(2);

    // CTRL write on the INT edge keeps the written EN
    rise_q.delete();
    bus_write(REG_PRESET, 32'd2);
    bus_write(REG_CTRL, 32'h9);
    wc = cyc;
    expect_rise("ie_rise1", wc + 5, 10);
    bus_write(REG_CTRL, 32'h9);
    read_expect("ie_ctrl_kept", REG_CTRL, 32'h9);
    check_eq("ie_irq_clr", 32'(irq), 32'd0);
    step(2);
    check_eq("ie_state_cnt", 32'(dut.state), 32'(CNT));
    expect_rise("ie_rise2", wc + 11, 10);

    // Asynchronous reset drops irq without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_irq", 32'(irq), 32'd0);
    check_all_zero("areset");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-count at COUNT=4
    rise_q.delete();
    bus_write(REG_PRESET, 32'd10);
    bus_write(REG_CTRL, 32'h9);
    step(8);
    read_expect("midreset_count4", REG_COUNT, 32'd4);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    step(15);
    check_all_zero("post_reset");
    check_eq("post_reset_no_rise", 32'(rise_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tc_timer.md
# tc_timer

Memory-mapped countdown timer peripheral for the P7 MIPS system, placed behind the CPU's data-bus bridge at base 0x7F00 alongside the external interrupt generator at 0x7F20. It holds a 32-bit preset, counts down when enabled and raises an interrupt request. The bridge combines that request into the CPU's hardware-interrupt vector, which CP0 then takes. It supports one-shot and auto-reload modes.

## Interface
- No parameters; the register layout is fixed.
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- addr  in  30  word address bits [31:2] from the bridge; only [3:2] are decoded
- we  in  1  write strobe, asserted only for full-word stores to this device
- wdata  in  32  write data
- rdata  out  32  combinational read data selected by addr[3:2]
- irq  out  1  interrupt request to the bridge/CP0, level-sensitive

## Operation
- Registers, selected by addr[3:2]:
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; bits 31:4 read as 0.
  - 1 PRESET: 32-bit, read/write.
  - 2 COUNT: 32-bit, read-only; writes are ignored.
  - 3: reserved; reads 0, writes are ignored.
- MODE encoding: 00 = one-shot, 01 = auto-reload. Codes 10 and 11 behave as 00.
- State machine (IDLE, LOAD, CNT, INT), one transition per clock edge:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT held. Otherwise, if COUNT=0, go to INT and set irq_flag. Otherwise COUNT <= COUNT-1.
  - INT, one-shot: clear EN and go to IDLE; irq_flag stays set.
  - INT, auto-reload: clear irq_flag and go to LOAD.
- irq = irq_flag & IM.
- irq_flag is cleared by any bus write to CTRL or PRESET, in addition to the auto-reload clear above.
- Simultaneous events:
  - A bus write to CTRL on the same edge that INT clears EN: the bus value wins.
  - A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
  - If the same edge both sets irq_flag and carries a CTRL/PRESET write, the write clears irq_flag. The timeout is lost by design.
- Arithmetic is unsigned 32-bit. COUNT never wraps because the decrement is gated by COUNT≠0.
- PRESET=0 is legal: LOAD loads 0, and INT is reached at the next edge.
- Reset, including assertion mid-count: CTRL, PRESET, COUNT and irq_flag go to 0, state goes to IDLE, and irq drops to 0 immediately (asynchronously). rdata then reads 0 for every address.

## Timing
- A register write is captured at the rising edge where we=1 (edge E0) and is readable right after it. Read has zero-cycle latency.
- Enabling (CTRL write with EN=1 at E0, PRESET=N):
  - E1: enter LOAD.
  - E2: COUNT=N, enter CNT.
  - E(2+k): COUNT=N-k.
  - E(3+N): enter INT, irq rises (if IM=1). irq is therefore high N+3 cycles after E0.
- One-shot: irq stays high until a CTRL or PRESET write or reset; the state is IDLE one edge after INT.
- Auto-reload: irq is high for exactly one cycle. The period is N+3 cycles, with COUNT=N again two edges after irq rises.
- Clearing EN during CNT: COUNT freezes from the next edge.

## Structure
- Package tc_pkg holds:
  - state enum (IDLE/LOAD/CNT/INT)
  - register offsets (CTRL=0, PRESET=1, COUNT=2)
  - MODE codes
  - CTRL bit positions
  - device base address 0x7F00 and size 0x0C, for bridge decode
- Single flat module with no sub-module. The register file and FSM are small enough to stay together.

## Test plan
- Reset mid-count: PRESET=10, EN=1, assert reset at COUNT=4 → all reads 0, irq=0, state IDLE; after release it stays idle with no irq.
- One-shot: PRESET=5, CTRL=0x9 (EN, IM, mode 00) → irq rises exactly 8 cycles after the write edge; CTRL reads 0x8; irq holds until a CTRL write of 0x8, after which irq drops on the next edge.
- Auto-reload: PRESET=3, CTRL=0xB → 1-cycle irq pulses every 6 cycles; COUNT reads 3,2,1,0 between pulses; 4 pulses in 24 cycles.
- Masking: PRESET=2, CTRL=0x1 (IM=0) → irq never rises; internal flag set; a later CTRL write of 0x8 clears the flag, so irq stays 0.
- Pause: PRESET=20, enable, write CTRL=0x8 when COUNT=12 → COUNT holds at 12 ±1 edge for 10 cycles; re-enable → LOAD reloads 20.
- Edges: PRESET=0 with EN → irq 3 cycles after the write. A COUNT write is ignored. The address 3 slot reads 0. A CTRL write on the INT edge keeps the written EN.
